// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the pipeline controller: instruction field positions,
// opcode/aluop encodings, controller FSM state codes and the decode bundle
// returned by hazard_dec.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Instruction field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_LSB  = 22;
  localparam int RS_LSB  = 17;
  localparam int RT_LSB  = 12;
  localparam int ALU_MSB = 6;
  localparam int ALU_LSB = 2;

  // Opcode / aluop encodings
  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // Controller FSM states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Decode results for the instruction pair in F/D and D/X
  typedef struct packed {
    logic load_use;
    logic is_mul;
    logic is_div;
  } dec_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle between the datapath (master) and the pipeline controller (slave).
//   master drives : ir_fd, ir_dx, ir_xm, br_taken, md_ready, md_exc
//   slave drives  : ena_pc/fd/dx/xm, clrn_fd/dx/xm, md_mul, md_div,
//                   md_busy, md_err, stall_cnt
// -----------------------------------------------------------------------------
interface pipe_ctrl_if;
  logic [31:0] ir_fd;
  logic [31:0] ir_dx;
  logic [31:0] ir_xm;
  logic        br_taken;
  logic        md_ready;
  logic        md_exc;
  logic        ena_pc;
  logic        ena_fd;
  logic        ena_dx;
  logic        ena_xm;
  logic        clrn_fd;
  logic        clrn_dx;
  logic        clrn_xm;
  logic        md_mul;
  logic        md_div;
  logic        md_busy;
  logic        md_err;
  logic [15:0] stall_cnt;

  modport master (
    output ir_fd, ir_dx, ir_xm, br_taken, md_ready, md_exc,
    input  ena_pc, ena_fd, ena_dx, ena_xm, clrn_fd, clrn_dx, clrn_xm,
    input  md_mul, md_div, md_busy, md_err, stall_cnt
  );

  modport slave (
    input  ir_fd, ir_dx, ir_xm, br_taken, md_ready, md_exc,
    output ena_pc, ena_fd, ena_dx, ena_xm, clrn_fd, clrn_dx, clrn_xm,
    output md_mul, md_div, md_busy, md_err, stall_cnt
  );
endinterface

// File: rtl/hazard_dec.sv
// -----------------------------------------------------------------------------
// hazard_dec
// Combinational decode of the F/D and D/X instruction words.
//   i_ir_fd : instruction in F/D
//   i_ir_dx : instruction in D/X
//   o_dec   : load_use (lw in D/X feeds rs/rt of F/D), is_mul, is_div (D/X)
// -----------------------------------------------------------------------------
module hazard_dec
  import pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [31:0] i_ir_fd,
  input  logic [31:0] i_ir_dx,
  output dec_t        o_dec
);

  logic [4:0]       w_op_dx;
  logic [4:0]       w_alu_dx;
  logic [REG_W-1:0] w_rd_dx;
  logic [REG_W-1:0] w_rs_fd;
  logic [REG_W-1:0] w_rt_fd;
  logic             w_unused;

  assign w_op_dx  = i_ir_dx[OPC_MSB:OPC_LSB];
  assign w_alu_dx = i_ir_dx[ALU_MSB:ALU_LSB];
  assign w_rd_dx  = i_ir_dx[RD_LSB +: REG_W];
  assign w_rs_fd  = i_ir_fd[RS_LSB +: REG_W];
  assign w_rt_fd  = i_ir_fd[RT_LSB +: REG_W];

  assign o_dec.is_mul = (w_op_dx == OP_ALU) && (w_alu_dx == ALU_MUL);
  assign o_dec.is_div = (w_op_dx == OP_ALU) && (w_alu_dx == ALU_DIV);
  // r0 is hard-wired zero, so a load into it never creates a dependency
  assign o_dec.load_use = (w_op_dx == OP_LW) && (w_rd_dx != '0) &&
                          ((w_rd_dx == w_rs_fd) || (w_rd_dx == w_rt_fd));

  // Remaining instruction bits are not needed for hazard detection
  assign w_unused = ^{i_ir_fd, i_ir_dx};

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline stall/flush controller with multiply/divide sequencing.
//   clk   : clock, rising edge
//   clrn  : asynchronous active-low reset
//   bus   : pipe_ctrl_if.slave (instruction words, branch/md status in;
//           latch enables, latch clears, md start pulses, status out)
// Parameters: MD_TIMEOUT (watchdog limit in RUN cycles), REG_W (reg field).
// Optional feature: define PIPE_CTRL_WDOG_EN to enable the RUN watchdog that
// sets md_err and abandons the operation after MD_TIMEOUT cycles.
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int REG_W      = 5
) (
  input logic        clk,
  input logic        clrn,
  pipe_ctrl_if.slave bus
);

  dec_t        w_dec;
  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_skip;
  logic [15:0] r_stall_cnt;
  logic        w_flush;
  logic        w_start;
  logic        w_timeout;
  logic        w_ena_pc, w_ena_fd, w_ena_dx, w_ena_xm;
  logic        w_clr_fd, w_clr_dx, w_clr_xm;
  logic        w_mul, w_div;
  logic        w_unused;

  hazard_dec #(.REG_W(REG_W)) u_hazard_dec (
    .i_ir_fd (bus.ir_fd),
    .i_ir_dx (bus.ir_dx),
    .o_dec   (w_dec)
  );

  // A branch resolved while the md unit runs belongs to a frozen X stage
  assign w_flush = bus.br_taken && (r_state != S_RUN);
  // r_skip masks the first cycle after reset: D/X may hold a stale mul/div
  assign w_start = (r_state == S_IDLE) && !r_skip && !w_flush &&
                   (w_dec.is_mul || w_dec.is_div);

  // Next-state and pipeline control decode
  always_comb begin
    w_state_nxt = r_state;
    w_ena_pc = 1'b1; w_ena_fd = 1'b1; w_ena_dx = 1'b1; w_ena_xm = 1'b1;
    w_clr_fd = 1'b1; w_clr_dx = 1'b1; w_clr_xm = 1'b1;
    w_mul = 1'b0; w_div = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_flush) begin
          w_clr_fd = 1'b0;
          w_clr_dx = 1'b0;
        end else if (w_start) begin
          // Freeze from the start cycle on so the operands stay put
          w_ena_pc = 1'b0; w_ena_fd = 1'b0; w_ena_dx = 1'b0; w_ena_xm = 1'b0;
          w_clr_xm = 1'b0;
          w_mul = w_dec.is_mul;
          w_div = w_dec.is_div;
          w_state_nxt = S_RUN;
        end else if (w_dec.load_use) begin
          w_ena_pc = 1'b0;
          w_ena_fd = 1'b0;
          w_clr_dx = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_ena_pc = 1'b0; w_ena_fd = 1'b0; w_ena_dx = 1'b0; w_ena_xm = 1'b0;
        w_clr_xm = 1'b0;
        if (bus.md_ready) begin
          w_state_nxt = S_DONE;
        end else if (w_timeout) begin
          // Bubble D/X so the abandoned mul/div is not restarted from IDLE
          w_ena_dx = 1'b1;
          w_clr_dx = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        // Everything advances: X/M captures the result, D/X moves on
        if (w_flush) begin
          w_clr_fd = 1'b0;
          w_clr_dx = 1'b0;
        end else begin
          w_clr_fd = 1'b1;
        end
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state, post-reset start mask and saturating stall counter
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= S_IDLE;
      r_skip      <= 1'b1;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= 1'b0;
      if (!w_ena_pc && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

`ifdef PIPE_CTRL_WDOG_EN
  localparam int WD_W = $clog2(MD_TIMEOUT + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_md_err;

  assign w_timeout = (r_state == S_RUN) && !bus.md_ready &&
                     (r_wd_cnt == WD_W'(MD_TIMEOUT - 1));

  // Watchdog: counts RUN cycles, latches a sticky error on expiry
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wd_cnt <= '0;
      r_md_err <= 1'b0;
    end else begin
      if ((r_state == S_RUN) && !bus.md_ready) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end else begin
        r_wd_cnt <= '0;
      end
      if (w_timeout) begin
        r_md_err <= 1'b1;
      end else begin
        r_md_err <= r_md_err;
      end
    end
  end

  assign bus.md_err = r_md_err;
  assign w_unused   = ^{bus.ir_xm, bus.md_exc};
`else
  assign w_timeout  = 1'b0;
  assign bus.md_err = 1'b0;
  assign w_unused   = ^{bus.ir_xm, bus.md_exc, 32'(MD_TIMEOUT)};
`endif

  // During reset the latches are held clear while their enables stay on
  assign bus.ena_pc    = !clrn || w_ena_pc;
  assign bus.ena_fd    = !clrn || w_ena_fd;
  assign bus.ena_dx    = !clrn || w_ena_dx;
  assign bus.ena_xm    = !clrn || w_ena_xm;
  assign bus.clrn_fd   = clrn && w_clr_fd;
  assign bus.clrn_dx   = clrn && w_clr_dx;
  assign bus.clrn_xm   = clrn && w_clr_xm;
  assign bus.md_mul    = clrn && w_mul;
  assign bus.md_div    = clrn && w_div;
  assign bus.md_busy   = (r_state == S_RUN);
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl. Each stimulus row pushes its expected
// output snapshot into a queue; the snapshot is popped and compared against
// the DUT just before the next rising edge. Build with PIPE_CTRL_WDOG_EN
// defined to exercise the watchdog instead of stall-counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  typedef struct packed {
    logic [3:0]  ena;   // {pc, fd, dx, xm}
    logic [2:0]  clr;   // {fd, dx, xm}
    logic        mul;
    logic        dv;
    logic        busy;
    logic        err;
    logic [15:0] stall;
  } obs_t;

  typedef struct packed {
    logic        clrn;
    logic [31:0] fd;
    logic [31:0] dx;
    logic        br;
    logic        rdy;
    logic        exc;
    logic [3:0]  ena;
    logic [2:0]  clr;
    logic        mul;
    logic        dv;
    logic        busy;
  } vec_t;

  logic clk;
  logic clrn;
  pipe_ctrl_if bus_if ();

  pipe_ctrl #(.MD_TIMEOUT(40), .REG_W(5)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t        exp_q[$];
  logic [15:0] exp_stall;
  logic        exp_err;
  int          n_vec;
  int          n_err;

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] alu);
    return {op, rd, rs, rt, 5'd0, alu, 2'd0};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd);
    return ins(5'b01000, rd, 5'd1, 5'd0, 5'd0);
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt);
    return ins(5'b00000, rd, rs, rt, 5'b00001);
  endfunction

  function automatic logic [31:0] mul_i();
    return ins(5'b00000, 5'd2, 5'd3, 5'd4, 5'b00110);
  endfunction

  function automatic logic [31:0] div_i();
    return ins(5'b00000, 5'd2, 5'd3, 5'd4, 5'b00111);
  endfunction

  function automatic vec_t mkv(input logic c, input logic [31:0] fd, input logic [31:0] dx,
                               input logic br, input logic rdy, input logic exc,
                               input logic [3:0] ena, input logic [2:0] clr,
                               input logic m, input logic d, input logic busy);
    vec_t v;
    v = '{c, fd, dx, br, rdy, exc, ena, clr, m, d, busy};
    return v;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ena   = {bus_if.ena_pc, bus_if.ena_fd, bus_if.ena_dx, bus_if.ena_xm};
    o.clr   = {bus_if.clrn_fd, bus_if.clrn_dx, bus_if.clrn_xm};
    o.mul   = bus_if.md_mul;
    o.dv    = bus_if.md_div;
    o.busy  = bus_if.md_busy;
    o.err   = bus_if.md_err;
    o.stall = bus_if.stall_cnt;
    return o;
  endfunction

  // Drive one row at the falling edge and queue its expected snapshot
  task automatic apply(input vec_t v);
    obs_t e;
    @(negedge clk);
    clrn            = v.clrn;
    bus_if.ir_fd    = v.fd;
    bus_if.ir_dx    = v.dx;
    bus_if.ir_xm    = 32'd0;
    bus_if.br_taken = v.br;
    bus_if.md_ready = v.rdy;
    bus_if.md_exc   = v.exc;
    if (!v.clrn) begin
      exp_stall = 16'd0;
      exp_err   = 1'b0;
    end
    e = {v.ena, v.clr, v.mul, v.dv, v.busy, exp_err, exp_stall};
    exp_q.push_back(e);
    if (v.clrn && !v.ena[3] && (exp_stall != 16'hFFFF)) exp_stall = exp_stall + 16'd1;
  endtask

  task automatic test_reset();
    vec_t tbl[$];
    obs_t got, e;
    tbl.push_back(mkv(1'b0, add(5'd4,5'd3,5'd5), mul_i(), 1'b1, 1'b0, 1'b0, 4'b1111, 3'b000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, add(5'd4,5'd3,5'd5), lw(5'd3), 1'b0, 1'b0, 1'b0, 4'b1111, 3'b000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 3'b111, 1'b0, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #2; got = sample(); e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL reset[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_load_use();
    vec_t tbl[$];
    obs_t got, e;
    tbl.push_back(mkv(1'b1, add(5'd4,5'd3,5'd5), lw(5'd3), 1'b0, 1'b0, 1'b0, 4'b0011, 3'b101, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b1, add(5'd4,5'd3,5'd5), 32'd0,    1'b0, 1'b0, 1'b0, 4'b1111, 3'b111, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b1, add(5'd4,5'd5,5'd3), lw(5'd3), 1'b0, 1'b0, 1'b0, 4'b0011, 3'b101, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b1, add(5'd4,5'd0,5'd5), lw(5'd0), 1'b0, 1'b0, 1'b0, 4'b1111, 3'b111, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b1, add(5'd4,5'd6,5'd7), lw(5'd3), 1'b0, 1'b0, 1'b0, 4'b1111, 3'b111, 1'b0, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #2; got = sample(); e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL load_use[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_flush();
    vec_t tbl[$];
    obs_t got, e;
    tbl.push_back(mkv(1'b1, add(5'd4,5'd3,5'd5), lw(5'd3), 1'b1, 1'b0, 1'b0, 4'b1111, 3'b001, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b1, add(5'd4,5'd3,5'd5), mul_i(),  1'b1, 1'b0, 1'b0, 4'b1111, 3'b001, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 3'b111, 1'b0, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #2; got = sample(); e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL flush[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_mul();
    vec_t tbl[$];
    obs_t got, e;
    logic [15:0] stall0;
    stall0 = exp_stall;
    tbl.push_back(mkv(1'b1, add(5'd9,5'd1,5'd2), mul_i(), 1'b0, 1'b0, 1'b0, 4'b0000, 3'b110, 1'b1, 1'b0, 1'b0));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mkv(1'b1, add(5'd9,5'd1,5'd2), mul_i(), 1'b0, 1'b0, 1'b0, 4'b0000, 3'b110, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b1, add(5'd9,5'd1,5'd2), mul_i(), 1'b0, 1'b1, 1'b0, 4'b0000, 3'b110, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b1, add(5'd9,5'd1,5'd2), mul_i(), 1'b0, 1'b0, 1'b0, 4'b1111, 3'b111, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 3'b111, 1'b0, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #2; got = sample(); e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL mul[%0d] got=%h exp=%h", i, got, e); end
    end
    n_vec++;
    if (bus_if.stall_cnt !== stall0 + 16'd6) begin
      n_err++; $display("FAIL mul_stall_total got=%0d exp=%0d", bus_if.stall_cnt, stall0 + 16'd6);
    end
  endtask

  task automatic test_back_to_back();
    vec_t tbl[$];
    obs_t got, e;
    tbl.push_back(mkv(1'b1, 32'd0, div_i(), 1'b0, 1'b0, 1'b0, 4'b0000, 3'b110, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mkv(1'b1, 32'd0, div_i(), 1'b1, 1'b0, 1'b0, 4'b0000, 3'b110, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b1, 32'd0, div_i(), 1'b0, 1'b1, 1'b1, 4'b0000, 3'b110, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b1, 32'd0, div_i(), 1'b0, 1'b0, 1'b0, 4'b1111, 3'b111, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b1, add(5'd4,5'd3,5'd5), lw(5'd3), 1'b0, 1'b0, 1'b0, 4'b0011, 3'b101, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 3'b111, 1'b0, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #2; got = sample(); e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

`ifdef PIPE_CTRL_WDOG_EN
  task automatic test_wdog();
    vec_t tbl[$];
    obs_t got, e;
    tbl.push_back(mkv(1'b1, 32'd0, div_i(), 1'b0, 1'b0, 1'b0, 4'b0000, 3'b110, 1'b0, 1'b1, 1'b0));
    for (int k = 1; k < 40; k++)
      tbl.push_back(mkv(1'b1, 32'd0, div_i(), 1'b0, 1'b0, 1'b0, 4'b0000, 3'b110, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b1, 32'd0, div_i(), 1'b0, 1'b0, 1'b0, 4'b0010, 3'b100, 1'b0, 1'b0, 1'b1));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #2; got = sample(); e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL wdog[%0d] got=%h exp=%h", i, got, e); end
    end
    exp_err = 1'b1;
    apply(mkv(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 3'b111, 1'b0, 1'b0, 1'b0));
    #2; got = sample(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL wdog_idle got=%h exp=%h", got, e); end
  endtask
`else
  task automatic test_saturate();
    obs_t got, e;
    apply(mkv(1'b1, 32'd0, mul_i(), 1'b0, 1'b0, 1'b0, 4'b0000, 3'b110, 1'b1, 1'b0, 1'b0));
    #2; got = sample(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL sat_start got=%h exp=%h", got, e); end
    for (int k = 0; k < 65540; k++) begin
      apply(mkv(1'b1, 32'd0, mul_i(), 1'b0, 1'b0, 1'b0, 4'b0000, 3'b110, 1'b0, 1'b0, 1'b1));
      #2; got = sample(); e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL sat_run[%0d] got=%h exp=%h", k, got, e); end
    end
    n_vec++;
    if (bus_if.stall_cnt !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_value got=%h exp=%h", bus_if.stall_cnt, 16'hFFFF);
    end
    apply(mkv(1'b1, 32'd0, mul_i(), 1'b0, 1'b1, 1'b0, 4'b0000, 3'b110, 1'b0, 1'b0, 1'b1));
    #2; got = sample(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL sat_ready got=%h exp=%h", got, e); end
    apply(mkv(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 3'b111, 1'b0, 1'b0, 1'b0));
    #2; got = sample(); e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_err++; $display("FAIL sat_done got=%h exp=%h", got, e); end
  endtask
`endif

  task automatic test_reset_in_run();
    vec_t tbl[$];
    obs_t got, e;
    tbl.push_back(mkv(1'b1, 32'd0, mul_i(), 1'b0, 1'b0, 1'b0, 4'b0000, 3'b110, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b1, 32'd0, mul_i(), 1'b0, 1'b0, 1'b0, 4'b0000, 3'b110, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b1, 32'd0, mul_i(), 1'b0, 1'b0, 1'b0, 4'b0000, 3'b110, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b0, 32'd0, mul_i(), 1'b0, 1'b0, 1'b0, 4'b1111, 3'b000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b1, 32'd0, mul_i(), 1'b0, 1'b0, 1'b0, 4'b1111, 3'b111, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b1, 32'd0, 32'd0,   1'b0, 1'b0, 1'b0, 4'b1111, 3'b111, 1'b0, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #2; got = sample(); e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin n_err++; $display("FAIL reset_in_run[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_stall = 16'd0;
    exp_err   = 1'b0;
    clrn = 1'b0;
    bus_if.ir_fd = 32'd0;
    bus_if.ir_dx = 32'd0;
    bus_if.ir_xm = 32'd0;
    bus_if.br_taken = 1'b0;
    bus_if.md_ready = 1'b0;
    bus_if.md_exc   = 1'b0;
    test_reset();
    test_load_use();
    test_flush();
    test_mul();
    test_back_to_back();
`ifdef PIPE_CTRL_WDOG_EN
    test_wdog();
`else
    test_saturate();
`endif
    test_reset_in_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
